ahb_lite_master_bridge: RTL and testbench
=========================================

// Module: ahb_lite_master_bridge
// PURPOSE
//  Single-outstanding AHB-Lite master converting core load/store requests (valid/ready) into
//  NONSEQ single transfers. Sits directly upstream of the wait-state memory slave: drives its
//  HADDR/HTRANS/HWRITE/HWDATA, consumes HREADYOUT/HRDATA/HRESP, returns one response per request.
// PARAMETERS
//  ADDR_W          32   address width (HADDR)
//  DATA_W          32   data width (HWDATA/HRDATA); only word transfers are issued
//  TIMEOUT_CYCLES  64   data-phase wait-cycle limit; used only with AHB_MST_TIMEOUT_EN
// PORTS
//  HCLK       in   1       clock; all state updates on rising edge
//  HRESETn    in   1       reset, asynchronous assert, active-low
//  req_valid  in   1       core request valid
//  req_ready  out  1       bridge accepts request (high only in IDLE)
//  req_write  in   1       1 = store, 0 = load
//  req_addr   in   ADDR_W  byte address, forwarded unmodified (alignment checked by slave)
//  req_wdata  in   DATA_W  store data
//  rsp_valid  out  1       response valid, held until rsp_ready
//  rsp_ready  in   1       core accepts response
//  rsp_rdata  out  DATA_W  load data (0 for stores and errors)
//  rsp_err    out  1       slave returned HRESP=1 or timeout fired
//  timeout    out  1       1-cycle pulse on timeout abort; constant 0 without macro
//  HADDR      out  ADDR_W  AHB address;  HSIZE out 3: constant 3'b010
//  HTRANS     out  2       IDLE=2'b00 / NONSEQ=2'b10 only
//  HWRITE     out  1       AHB write;   HWDATA out DATA_W: AHB write data
//  HREADY     in   1       slave HREADYOUT (transfer done)
//  HRDATA     in   DATA_W  read data;   HRESP in 1: 0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset (async): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; timeout=0;
//   HADDR=0; HTRANS=IDLE; HWRITE=0; HWDATA=0. Reset mid-transfer abandons it, no response.
//  FSM IDLE -> ADDR -> DATA -> RESP -> IDLE.
//  IDLE: req_ready=1, HTRANS=IDLE. req_valid&&req_ready: register addr/write/wdata, goto ADDR.
//  ADDR: HTRANS=NONSEQ, HADDR/HWRITE from regs. HREADY=1 -> DATA; HREADY=0 -> stay (hold all).
//  DATA: HTRANS=IDLE; HADDR, HWRITE held from ADDR for the whole data phase (slave samples
//   HWRITE in data phase); HWDATA=wdata reg if write else 0. HREADY=0 -> stay (wait state).
//   HREADY=1 -> capture rsp_err=HRESP, rsp_rdata=(!write && !HRESP)?HRDATA:0; goto RESP.
//  RESP: rsp_valid=1, outputs stable; rsp_ready=1 -> IDLE next cycle; HTRANS=IDLE, HWRITE=0.
//  rsp_valid and req_ready never high together; next request accepted >=1 cycle after handshake.
//  Latency, zero-wait slave: accept at cycle 0, NONSEQ at 1, data at 2, rsp_valid at 3.
//   Each slave wait cycle adds exactly one cycle. No pipelining: one transfer outstanding.
//  HTRANS never BUSY/SEQ; no bursts; HSIZE constant word.
// CONFIGURATION
//  AHB_MST_TIMEOUT_EN defined: counter clears on entering DATA, increments per DATA cycle with
//   HREADY=0; reaching TIMEOUT_CYCLES -> RESP with rsp_err=1, rsp_rdata=0, timeout pulse 1 cycle.
//   Late HREADY for the aborted transfer is ignored; bridge still holds HTRANS=IDLE.
//  Undefined: no counter; DATA waits indefinitely; timeout tied 0.
// TESTING
//  Reset mid DATA phase -> all outputs at reset values next cycle, no rsp_valid after release.
//  Write 0xDEADBEEF to 0x10, slave 4 wait states -> NONSEQ 1 cycle, HWRITE=1 held 5 data
//   cycles, HWDATA=0xDEADBEEF; rsp_valid, rsp_err=0 at cycle 7 after accept.
//  Read 0x10 after write -> rsp_rdata=0xDEADBEEF, rsp_err=0, HWRITE=0 throughout.
//  Read 0x13 (unaligned), slave HRESP=1 -> rsp_err=1, rsp_rdata=0.
//  rsp_ready held 0 for 3 cycles with req_valid=1 -> req_ready=0, rsp stable; new accept
//   only the cycle after rsp_ready=1.
//  AHB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=8, HREADY stuck 0 in DATA -> after 8 wait cycles
//   rsp_err=1, timeout pulses once; without macro bridge stays in DATA.

Source files
------------

// File: rtl/ahb_lite_master_bridge_if.sv
// Purpose : Bundle of core request/response handshake and AHB-Lite master bus signals.
// Latency : n/a (wires only).
// Backpr. : req_valid/req_ready and rsp_valid/rsp_ready handshakes; HREADY stalls the AHB side.
// Ports   : master modport = bridge view (drives req_ready, rsp_*, timeout, HADDR/HSIZE/HTRANS/
//           HWRITE/HWDATA); slave modport = environment view (core + AHB slave).
interface ahb_lite_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // core request channel
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    // core response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              timeout;
    // AHB-Lite master side
    logic [ADDR_W-1:0] HADDR;
    logic [2:0]        HSIZE;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HRESP;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  HREADY, HRDATA, HRESP,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, timeout,
        output HADDR, HSIZE, HTRANS, HWRITE, HWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output HREADY, HRDATA, HRESP,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, timeout,
        input  HADDR, HSIZE, HTRANS, HWRITE, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master_bridge.sv
// Purpose : Single-outstanding AHB-Lite master turning core load/store requests into NONSEQ words.
// Latency : accept at cycle 0, NONSEQ at 1, data phase at 2, rsp_valid at 3; +1 per slave wait.
// Backpr. : req_ready only in IDLE; rsp_valid held until rsp_ready; HREADY=0 stalls ADDR/DATA.
// Ports   : HCLK, HRESETn (async, active-low) plus bus (ahb_lite_master_bridge_if.master).
// Config  : define AHB_MST_TIMEOUT_EN to abort a data phase after TIMEOUT_CYCLES wait cycles;
//           without it the data phase waits indefinitely and timeout is tied low.
module ahb_lite_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic HCLK,
    input  logic HRESETn,
    ahb_lite_master_bridge_if.master bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;
    logic              expire;

`ifdef AHB_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Fires on the wait cycle that would make the count reach TIMEOUT_CYCLES.
    assign expire = (state_q == S_DATA) && !bus.HREADY &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = expire;
        if (state_q == S_ADDR && bus.HREADY) begin
            cnt_d = '0;
        end else if (state_q == S_DATA && !bus.HREADY) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    // The wait limit only has meaning in the timeout build.
    wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);

    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Next-state and capture logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    write_d = bus.req_write;
                    wdata_d = bus.req_wdata;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.HREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.HREADY) begin
                    err_d   = bus.HRESP;
                    rdata_d = (!write_q && !bus.HRESP) ? bus.HRDATA : '0;
                    state_d = S_RESP;
                end else if (expire) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // HADDR/HWRITE stay up through the data phase because the slave samples HWRITE there.
    assign bus.HADDR  = addr_q;
    assign bus.HSIZE  = 3'b010;
    assign bus.HTRANS = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HWRITE = write_q && (state_q == S_ADDR || state_q == S_DATA);
    assign bus.HWDATA = (state_q == S_DATA && write_q) ? wdata_q : '0;

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
module tb_ahb_lite_master_bridge;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ahb_lite_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    ahb_lite_master_bridge #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .HCLK   (clk),
        .HRESETn(rst_n),
        .bus    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        hresp;
        logic [31:0] hrdata;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts just after a negedge with the bridge idle; ends the same way.
    task automatic run_vec(input int idx, input vec_t v);
        chk($sformatf("v%0d req_ready idle", idx), 64'(bif.req_ready), 64'd1);
        bif.req_valid = 1'b1;
        bif.req_write = v.wr;
        bif.req_addr  = v.addr;
        bif.req_wdata = v.wdata;
        @(negedge clk);
        bif.req_valid = 1'b0;
        chk($sformatf("v%0d htrans nonseq", idx), 64'(bif.HTRANS), 64'h2);
        chk($sformatf("v%0d haddr", idx), 64'(bif.HADDR), 64'(v.addr));
        chk($sformatf("v%0d hwrite addr", idx), 64'(bif.HWRITE), 64'(v.wr));
        chk($sformatf("v%0d req_ready busy", idx), 64'(bif.req_ready), 64'd0);
        bif.HREADY = 1'b1;
        bif.HRESP  = 1'b0;
        for (int w = 0; w <= v.waits; w++) begin
            @(negedge clk);
            chk($sformatf("v%0d d%0d htrans", idx, w), 64'(bif.HTRANS), 64'h0);
            chk($sformatf("v%0d d%0d hwrite", idx, w), 64'(bif.HWRITE), 64'(v.wr));
            chk($sformatf("v%0d d%0d haddr", idx, w), 64'(bif.HADDR), 64'(v.addr));
            chk($sformatf("v%0d d%0d hwdata", idx, w), 64'(bif.HWDATA),
                v.wr ? 64'(v.wdata) : 64'd0);
            chk($sformatf("v%0d d%0d rsp_valid", idx, w), 64'(bif.rsp_valid), 64'd0);
            bif.HREADY = (w == v.waits);
            bif.HRESP  = (w == v.waits) ? v.hresp : 1'b0;
            bif.HRDATA = (w == v.waits) ? v.hrdata : 32'hCAFE_0000 + 32'(w);
        end
        for (int d = 0; d <= v.hold; d++) begin
            @(negedge clk);
            chk($sformatf("v%0d r%0d rsp_valid", idx, d), 64'(bif.rsp_valid), 64'd1);
            chk($sformatf("v%0d r%0d rsp_err", idx, d), 64'(bif.rsp_err), 64'(v.exp_err));
            chk($sformatf("v%0d r%0d rsp_rdata", idx, d), 64'(bif.rsp_rdata), 64'(v.exp_rdata));
            chk($sformatf("v%0d r%0d req_ready", idx, d), 64'(bif.req_ready), 64'd0);
            chk($sformatf("v%0d r%0d hwrite", idx, d), 64'(bif.HWRITE), 64'd0);
            chk($sformatf("v%0d r%0d htrans", idx, d), 64'(bif.HTRANS), 64'h0);
            bif.HREADY    = 1'b1;
            bif.HRESP     = 1'b0;
            bif.HRDATA    = 32'h5555_AAAA;
            bif.rsp_ready = (d == v.hold);
            bif.req_valid = (d < v.hold);
        end
        @(negedge clk);
        bif.rsp_ready = 1'b0;
        bif.req_valid = 1'b0;
        chk($sformatf("v%0d post rsp_valid", idx), 64'(bif.rsp_valid), 64'd0);
        chk($sformatf("v%0d post req_ready", idx), 64'(bif.req_ready), 64'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        //       wr    addr          wdata          waits hresp hrdata         hold exp_rdata     err
        vt[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4, 1'b0, 32'h0000_0000, 0, 32'h0000_0000, 1'b0};
        vt[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 0, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0};
        vt[2] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 0, 1'b1, 32'h1234_5678, 0, 32'h0000_0000, 1'b1};
        vt[3] = '{1'b1, 32'h0000_0020, 32'hA5A5_5A5A, 1, 1'b1, 32'h0000_0000, 0, 32'h0000_0000, 1'b1};
        vt[4] = '{1'b1, 32'h0000_0030, 32'h0123_4567, 0, 1'b0, 32'hFFFF_FFFF, 3, 32'h0000_0000, 1'b0};
        vt[5] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 2, 1'b0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 1'b0};

        rst_n         = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_write = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.rsp_ready = 1'b0;
        bif.HREADY    = 1'b1;
        bif.HRDATA    = '0;
        bif.HRESP     = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst req_ready", 64'(bif.req_ready), 64'd1);
        chk("rst rsp_valid", 64'(bif.rsp_valid), 64'd0);
        chk("rst rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
        chk("rst rsp_err", 64'(bif.rsp_err), 64'd0);
        chk("rst timeout", 64'(bif.timeout), 64'd0);
        chk("rst haddr", 64'(bif.HADDR), 64'd0);
        chk("rst htrans", 64'(bif.HTRANS), 64'd0);
        chk("rst hwrite", 64'(bif.HWRITE), 64'd0);
        chk("rst hwdata", 64'(bif.HWDATA), 64'd0);
        chk("rst hsize", 64'(bif.HSIZE), 64'h2);
        rst_n = 1'b1;
        @(negedge clk);

        // slave stuck in wait state during the data phase
        bif.req_valid = 1'b1;
        bif.req_write = 1'b1;
        bif.req_addr  = 32'h0000_0050;
        bif.req_wdata = 32'h7777_8888;
        @(negedge clk);
        bif.req_valid = 1'b0;
        chk("to nonseq", 64'(bif.HTRANS), 64'h2);
        bif.HREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("to wait%0d rsp_valid", i), 64'(bif.rsp_valid), 64'd0);
            chk($sformatf("to wait%0d hwrite", i), 64'(bif.HWRITE), 64'd1);
            chk($sformatf("to wait%0d timeout", i), 64'(bif.timeout), 64'd0);
            bif.HREADY = 1'b0;
        end
        @(negedge clk);
`ifdef AHB_MST_TIMEOUT_EN
        chk("to abort rsp_valid", 64'(bif.rsp_valid), 64'd1);
        chk("to abort timeout", 64'(bif.timeout), 64'd1);
        chk("to abort rsp_err", 64'(bif.rsp_err), 64'd1);
        chk("to abort rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
        bif.HREADY = 1'b1;
        bif.HRDATA = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("to pulse end", 64'(bif.timeout), 64'd0);
        chk("to held rsp_valid", 64'(bif.rsp_valid), 64'd1);
        chk("to late hready htrans", 64'(bif.HTRANS), 64'h0);
        chk("to held rsp_err", 64'(bif.rsp_err), 64'd1);
        bif.rsp_ready = 1'b1;
`else
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("nto stay%0d rsp_valid", i), 64'(bif.rsp_valid), 64'd0);
            chk($sformatf("nto stay%0d hwdata", i), 64'(bif.HWDATA), 64'h7777_8888);
            chk($sformatf("nto stay%0d timeout", i), 64'(bif.timeout), 64'd0);
            @(negedge clk);
        end
        bif.HREADY = 1'b1;
        bif.HRDATA = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("nto rsp_valid", 64'(bif.rsp_valid), 64'd1);
        chk("nto rsp_err", 64'(bif.rsp_err), 64'd0);
        chk("nto rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
        chk("nto timeout", 64'(bif.timeout), 64'd0);
        bif.rsp_ready = 1'b1;
`endif
        @(negedge clk);
        bif.rsp_ready = 1'b0;
        chk("to back idle", 64'(bif.req_ready), 64'd1);

        // table-driven transfers
        for (int i = 0; i < 6; i++) begin
            run_vec(i, vt[i]);
        end

        // reset asserted in the middle of a data phase
        bif.req_valid = 1'b1;
        bif.req_write = 1'b1;
        bif.req_addr  = 32'h0000_0040;
        bif.req_wdata = 32'h1111_2222;
        @(negedge clk);
        bif.req_valid = 1'b0;
        bif.HREADY    = 1'b1;
        @(negedge clk);
        chk("mr data hwrite", 64'(bif.HWRITE), 64'd1);
        bif.HREADY = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr htrans", 64'(bif.HTRANS), 64'h0);
        chk("mr hwrite", 64'(bif.HWRITE), 64'd0);
        chk("mr haddr", 64'(bif.HADDR), 64'd0);
        chk("mr hwdata", 64'(bif.HWDATA), 64'd0);
        chk("mr req_ready", 64'(bif.req_ready), 64'd1);
        chk("mr rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
        chk("mr rsp_valid", 64'(bif.rsp_valid), 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        bif.HREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("mr after%0d rsp_valid", i), 64'(bif.rsp_valid), 64'd0);
            chk($sformatf("mr after%0d htrans", i), 64'(bif.HTRANS), 64'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
